// File: rtl/xip_cache_ctrl_pkg.sv
// xip_cache_ctrl_pkg: shared state encoding and geometry defaults for the XIP cache
package xip_cache_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, RESP} state_t;
    localparam int NUM_LINES_DEF = 16;
    localparam int LINE_SIZE_DEF = 16;
    localparam int OFFS_W = $clog2(LINE_SIZE_DEF);
    localparam int IDX_W = $clog2(NUM_LINES_DEF);
    localparam int TAG_W = 24 - OFFS_W - IDX_W;
endpackage

// File: rtl/xip_cache_tag_array.sv
// xip_cache_tag_array: tag and valid storage with async read, sync write and clear-all
module xip_cache_tag_array
    import xip_cache_ctrl_pkg::*;
#(
    parameter int LINES = NUM_LINES_DEF,
    parameter int IW = IDX_W,
    parameter int TW = TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] rd_idx,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    output logic [TW-1:0] rd_tag,
    output logic          rd_valid
);
    logic [LINES-1:0] valid;
    logic [TW-1:0] tags [LINES];

    assign rd_tag = tags[rd_idx];
    assign rd_valid = valid[rd_idx];

    always_ff @(posedge clk) begin
        if (rst || clr) valid <= '0;
        else if (we) valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we) tags[wr_idx] <= wr_tag;
    end
endmodule

// File: rtl/xip_cache_ctrl.sv
// xip_cache_ctrl: direct-mapped execute-in-place read cache with single-line refill
module xip_cache_ctrl
    import xip_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int LINE_SIZE = LINE_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [23:0]            addr,
    input  logic                   flush,
    output logic                   ack,
    output logic [31:0]            rdata,
    output logic                   fill_rd,
    output logic [23:0]            fill_addr,
    input  logic                   fill_done,
    input  logic [LINE_SIZE*8-1:0] fill_line
);
    localparam int OW = $clog2(LINE_SIZE);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 24 - OW - IW;

    state_t state, state_nxt;
    logic ack_nxt, fp, fp_nxt, clr, we, hit, rd_valid;
    logic [31:0] rdata_nxt;
    logic [23:0] fill_addr_nxt;
    logic [TW-1:0] tag, rd_tag;
    logic [IW-1:0] idx;
    logic [OW+2:0] bsel;
    logic [LINE_SIZE*8-1:0] data [NUM_LINES];

    assign tag = addr[23 -: TW];
    assign idx = addr[OW +: IW];
    // bit position of the addressed word within a line, byte lane bits dropped
    assign bsel = {addr[OW-1:0], 3'b000} & ~(OW+3)'(31);
    assign hit = rd_valid && rd_tag == tag;
    assign fill_rd = state == FILL_REQ;

    xip_cache_tag_array #(.LINES(NUM_LINES), .IW(IW), .TW(TW)) u_tags (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .we(we),
        .rd_idx(idx),
        .wr_idx(idx),
        .wr_tag(tag),
        .rd_tag(rd_tag),
        .rd_valid(rd_valid)
    );

    always_comb begin
        state_nxt = state;
        ack_nxt = 1'b0;
        rdata_nxt = rdata;
        fill_addr_nxt = fill_addr;
        fp_nxt = fp;
        clr = 1'b0;
        we = 1'b0;
        case (state)
            IDLE: begin
                clr = flush;
                // a request still high during its own ack cycle is the one just served
                if (req && !ack) begin
                    if (hit && !flush) begin
                        ack_nxt = 1'b1;
                        rdata_nxt = data[idx][bsel +: 32];
                    end else begin
                        state_nxt = FILL_REQ;
                        fill_addr_nxt = {tag, idx, OW'(0)};
                    end
                end
            end
            FILL_REQ: begin
                fp_nxt = fp | flush;
                state_nxt = FILL_WAIT;
            end
            FILL_WAIT: begin
                fp_nxt = fp | flush;
                if (fill_done) begin
                    we = 1'b1;
                    ack_nxt = 1'b1;
                    rdata_nxt = fill_line[bsel +: 32];
                    state_nxt = RESP;
                end
            end
            RESP: begin
                clr = fp | flush;
                fp_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack <= 1'b0;
            rdata <= '0;
            fill_addr <= '0;
            fp <= 1'b0;
        end else begin
            state <= state_nxt;
            ack <= ack_nxt;
            rdata <= rdata_nxt;
            fill_addr <= fill_addr_nxt;
            fp <= fp_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (we) data[idx] <= fill_line;
    end
endmodule

// File: doc/xip_cache_ctrl.md
XIP_CACHE_CTRL -- requirements
Module: xip_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped cache lines (power of 2).
REQ-002 SHALL have parameter LINE_SIZE, default 16, bytes per line (power of 2, at least 4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  word-read request, held high until ack.
REQ-006 SHALL have port addr  input  24  flash byte address; held stable while req is high; addr[1:0] ignored.
REQ-007 SHALL have port flush  input  1  invalidate-all request, single-cycle pulse.
REQ-008 SHALL have port ack  output  1  one-cycle pulse; rdata valid in that cycle.
REQ-009 SHALL have port rdata  output  32  little-endian word addressed by addr[log2(LINE_SIZE)-1:2].
REQ-010 SHALL have port fill_rd  output  1  one-cycle line-fetch strobe to the flash line reader.
REQ-011 SHALL have port fill_addr  output  24  line-aligned fetch address; low log2(LINE_SIZE) bits zero.
REQ-012 SHALL have port fill_done  input  1  one-cycle pulse from the reader; fill_line is valid in that cycle.
REQ-013 SHALL have port fill_line  input  LINE_SIZE*8  fetched line; byte i at bits [8i+7:8i].

Function
REQ-014 SHALL split addr into offset [3:0], index [7:4] and tag [23:8] at the defaults, with widths derived from the parameters.
REQ-015 SHALL implement the FSM states IDLE, FILL_REQ, FILL_WAIT and RESP.
REQ-016 IDLE with req=1 and a hit (valid[index] and tag match) SHALL assert ack with rdata from the data array in the next cycle and stay in IDLE.
REQ-017 IDLE with req=1 and a miss SHALL go to FILL_REQ.
REQ-018 FILL_REQ SHALL assert fill_rd for exactly one cycle with fill_addr = {tag,index,0}, then go to FILL_WAIT.
REQ-019 fill_addr SHALL stay stable from FILL_REQ until fill_done.
REQ-020 FILL_WAIT on fill_done SHALL write fill_line, tag and valid=1 into the index line, capture the requested word from fill_line, and go to RESP.
REQ-021 RESP SHALL assert ack for one cycle with the captured word, then go to IDLE.
REQ-022 Miss latency SHALL be 1 cycle from req to fill_rd, and ack SHALL follow fill_done by exactly 1 cycle.
REQ-023 Hit latency SHALL be 1 cycle; back-to-back hits SHALL be acked on alternate cycles, since req must drop after ack before the next sampled request.
REQ-024 Outside IDLE, req SHALL be ignored; fill_done SHALL be ignored in every state except FILL_WAIT.
REQ-025 flush in IDLE SHALL clear all valid bits on that edge.
REQ-026 If flush and req coincide in IDLE, flush SHALL take effect first and the req SHALL be treated as a miss.
REQ-027 flush in FILL_REQ, FILL_WAIT or RESP SHALL set flush_pending, which is applied on entry to IDLE, after the in-flight line is written and acked.
REQ-028 A line refilled at the same index SHALL overwrite the tag and data unconditionally (no replacement choice).
REQ-029 ack and fill_rd SHALL never both be high in the same cycle.

Reset
REQ-030 rst SHALL force state to IDLE, clear all valid bits and flush_pending, and drive ack=0, fill_rd=0, fill_addr=0 and rdata=0.
REQ-031 rst in FILL_WAIT SHALL abandon the fill; the flash reader shares rst, so no stale fill_done SHALL be acted on.
REQ-032 The data and tag arrays SHALL NOT be reset.

Structure
REQ-033 A shared package SHALL hold the state enum, the NUM_LINES and LINE_SIZE defaults, and the derived OFFS_W, IDX_W and TAG_W constants.
REQ-034 Tag and valid storage SHALL be one sub-module, xip_cache_tag_array, with a combinational read port, a synchronous write port and a single-cycle clear-all input.

Verification
REQ-035 Cold miss: after reset, req with addr=0x000104 -> fill_rd with fill_addr=0x000100; on fill_done with fill_line word1=0xDEADBEEF -> ack next cycle with rdata=0xDEADBEEF.
REQ-036 Hit: repeat req with addr=0x00010C after REQ-035 -> ack 1 cycle later, no fill_rd, rdata equals fill_line[127:96].
REQ-037 Conflict: req with addr=0x010100 (same index 0, tag 0x0101) -> fill_rd with fill_addr=0x010100; a subsequent req with addr=0x000100 misses again.
REQ-038 Flush during fill: flush pulse in FILL_WAIT -> ack still delivered; the next req to the same line misses (fill_rd reasserted).
REQ-039 Simultaneous flush+req in IDLE on a cached line -> fill_rd issued, no immediate ack.
REQ-040 Reset mid-fill: rst in FILL_WAIT, then a fill_done pulse -> no ack; the next req misses from IDLE.
